bd_fetch_sched: RTL and testbench
=================================

Name: bd_fetch_sched

Overview:
Schedules BD (buffer descriptor) fetches for the four DMA BD rings: ch0 s2c, ch0 c2s, ch1 s2c and ch1 c2s.
- Tracks a head pointer per ring against a software-written tail doorbell.
- Round-robin arbitrates non-empty rings.
- Issues one burst read request at a time to the PCIe read-request engine.
- Sits between the MMIO BD base/high register outputs and the DMA engine's descriptor-read path.

Parameters:
MAX_BURST, 8, max BDs per request (power of 2, 1..64)
LEN_W, 7, width of req_len; must hold MAX_BURST

Ports:
user_clk  in  1  clock
axi_lite_aresetn  in  1  reset, asynchronous, active-low
q_base  in  4x27  per-ring BD base, 32-byte units (index 0..3 = ch0_s2c, ch0_c2s, ch1_s2c, ch1_c2s)
q_high  in  4x27  per-ring address of last BD, inclusive, 32-byte units
q_en  in  4  per-ring enable
tail_wr  in  4  per-ring tail doorbell strobe
tail_val  in  27  new tail value (shared by all strobes)
req_valid  out  1  fetch request valid
req_ready  in  1  engine accepts request
req_qid  out  2  ring index
req_addr  out  27  first BD address, 32-byte units
req_len  out  LEN_W  BD count, 1..MAX_BURST
cpl_valid  in  1  fetch completion strobe
cpl_qid  in  2  completed ring
cpl_err  in  1  completion carried an error
q_busy  out  4  ring has an outstanding request
q_halt  out  4  ring halted by error (sticky)

Behaviour:
- Clock and reset: one clock, user_clk. Reset axi_lite_aresetn is asynchronous, active-low.
- Reset values: req_valid=0, req_qid=0, req_addr=0, req_len=0, q_busy=0, q_halt=0. Internally: head=0, tail=0, rr pointer=3 (so ring 0 wins first).
- Ring enable:
  - Rising edge of q_en[i]: head[i]<=q_base[i], tail[i]<=q_base[i], q_halt[i]<=0.
  - While q_en[i]=0, ring i is never eligible.
- Tail doorbell: tail_wr[i] loads tail[i]<=tail_val in the same cycle. It has no effect if q_en[i]=0. Several bits may be set at once; all load tail_val.
- Eligibility: elig[i] = q_en[i] & ~q_busy[i] & ~q_halt[i] & (head[i]!=tail[i]). Empty means head==tail. Software never fills a ring completely.
- Contiguous BDs available:
  - tail>=head: avail = tail-head.
  - tail<head: avail = q_high-head+1 (a request never crosses high).
- Burst length: req_len = min(avail, MAX_BURST). Arithmetic is 27-bit unsigned, and the result is truncated to LEN_W only after the min.
- FSM, two states:
  - ARB: if any elig, the round-robin winner is the first eligible index after the rr pointer, modulo 4. On the next edge, register req_qid, req_addr=head, req_len; set req_valid=1; go to REQ. Otherwise stay in ARB.
  - REQ: hold req_valid and all req_* fields stable until req_ready. On the req_valid&req_ready edge:
    - req_valid<=0, q_busy[qid]<=1, rr<=qid.
    - head advances by req_len. If head+req_len > q_high, head<=q_base instead (wrap).
    - Return to ARB.
- Latency: one idle cycle minimum between requests; ARB always spends one cycle. Eligible-to-req_valid is 1 cycle.
- Tail update during REQ or at grant: arbitration uses the tail registered at the ARB decision. A new tail is picked up by the next arbitration.
- Completion:
  - cpl_valid with q_busy[cpl_qid]=1 clears q_busy[cpl_qid].
  - If cpl_err=1, also sets q_halt[cpl_qid].
  - cpl_valid for a non-busy ring is ignored, with no state change.
  - Completion and grant on the same ring in the same cycle cannot occur, because a busy ring is not eligible.
- q_en falling while ring i is in REQ: the request still completes its handshake, since req_valid is never dropped without ready. The ring stays busy until its completion arrives.
- Reset mid-request: req_valid drops immediately (async). The engine must be reset together with this block.

Decomposition:
- Shared package dma_bd_pkg holds:
  - constants BD_ADDR_W=27 and NUM_Q=4;
  - ring index constants Q_CH0_S2C=0, Q_CH0_C2S=1, Q_CH1_S2C=2, Q_CH1_C2S=3.
- Sub-module rr_arb4: a 4-way round-robin arbiter with inputs elig[3:0] and last[1:0], and outputs gnt_vld and gnt_id[1:0]. It is purely combinational and reusable by the C2S write-back scheduler.

Test Plan:
1. Enable ring 0 (base=0x100, high=0x10F) and write tail=0x103 -> one request: qid0, addr 0x100, len 3. Then cpl -> q_busy[0]=0 and head=0x103.
2. Ring 0 with base=0x100, head=0x10C, tail=0x102 (wrapped), MAX_BURST=8 -> request addr 0x10C len 4, head wraps to 0x100. After cpl, next request is addr 0x100 len 2.
3. Ring 0 tail=0x100+20 -> requests of len 8, 8, 4, each gated by cpl.
4. All four rings non-empty, cpl returned immediately each time -> grants in order 0,1,2,3,0. Hold req_ready=0 for 5 cycles -> req_* fields stable throughout.
5. cpl_err on ring 2 -> q_halt[2]=1 and no further ring-2 requests. Toggle q_en[2] -> halt cleared, head=tail=base.
6. Assert reset while req_valid=1 -> req_valid=0 in the same cycle, and all q_busy/q_halt=0.

Source files
------------

// File: rtl/dma_bd_pkg.sv
// Shared definitions for the DMA buffer-descriptor ring logic.
// Covers ring indexing, BD address width and the fetch scheduler state encoding.
package dma_bd_pkg;

  localparam int BD_ADDR_W = 27;
  localparam int NUM_Q     = 4;

  localparam logic [1:0] Q_CH0_S2C = 2'd0;
  localparam logic [1:0] Q_CH0_C2S = 2'd1;
  localparam logic [1:0] Q_CH1_S2C = 2'd2;
  localparam logic [1:0] Q_CH1_C2S = 2'd3;

  typedef logic [BD_ADDR_W-1:0] bd_addr_t;

  typedef enum logic {
    ST_ARB = 1'b0,
    ST_REQ = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin arbiter.
// Grants the first eligible index strictly after 'last', wrapping modulo 4.
module rr_arb4 (
  input  logic [3:0] elig,
  input  logic [1:0] last,
  output logic       gnt_vld,
  output logic [1:0] gnt_id
);

  logic [1:0] idx;

  // Scan from the farthest candidate back to the nearest so the nearest eligible one wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = last;
    idx     = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
  end

endmodule

// File: rtl/bd_fetch_sched.sv
// BD fetch scheduler for the four DMA descriptor rings.
// Tracks head/tail per ring, arbitrates round-robin and issues one burst read at a time.
module bd_fetch_sched
  import dma_bd_pkg::*;
#(
  parameter int MAX_BURST = 8,
  parameter int LEN_W     = 7
) (
  input  logic                                user_clk,
  input  logic                                axi_lite_aresetn,
  input  logic [NUM_Q-1:0][BD_ADDR_W-1:0]     q_base,
  input  logic [NUM_Q-1:0][BD_ADDR_W-1:0]     q_high,
  input  logic [NUM_Q-1:0]                    q_en,
  input  logic [NUM_Q-1:0]                    tail_wr,
  input  logic [BD_ADDR_W-1:0]                tail_val,
  output logic                                req_valid,
  input  logic                                req_ready,
  output logic [1:0]                          req_qid,
  output logic [BD_ADDR_W-1:0]                req_addr,
  output logic [LEN_W-1:0]                    req_len,
  input  logic                                cpl_valid,
  input  logic [1:0]                          cpl_qid,
  input  logic                                cpl_err,
  output logic [NUM_Q-1:0]                    q_busy,
  output logic [NUM_Q-1:0]                    q_halt
);

  bd_addr_t               head [NUM_Q];
  bd_addr_t               tail [NUM_Q];
  logic [NUM_Q-1:0]       q_en_d;
  logic [NUM_Q-1:0]       elig;
  logic [1:0]             rr_last;

  logic                   gnt_vld;
  logic [1:0]             gnt_id;

  bd_addr_t               win_head;
  bd_addr_t               win_tail;
  bd_addr_t               win_high;
  bd_addr_t               win_avail;
  logic [LEN_W-1:0]       win_len;

  logic [BD_ADDR_W:0]     adv_sum;
  bd_addr_t               next_head;

  fetch_state_e           state;
  fetch_state_e           state_nxt;
  logic                   grant_load;
  logic                   handshake;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      elig[i] = q_en[i] & ~q_busy[i] & ~q_halt[i] & (head[i] != tail[i]);
    end
  end

  rr_arb4 u_arb (
    .elig    (elig),
    .last    (rr_last),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  // A wrapped ring only offers the BDs up to high; the rest goes out on the next pass.
  always_comb begin
    win_head = head[gnt_id];
    win_tail = tail[gnt_id];
    win_high = q_high[gnt_id];
    if (win_tail >= win_head) begin
      win_avail = win_tail - win_head;
    end else begin
      win_avail = win_high - win_head + 1'b1;
    end
    if (win_avail > BD_ADDR_W'(MAX_BURST)) begin
      win_len = LEN_W'(MAX_BURST);
    end else begin
      win_len = win_avail[LEN_W-1:0];
    end
  end

  always_comb begin
    adv_sum = {1'b0, req_addr} + {{(BD_ADDR_W + 1 - LEN_W){1'b0}}, req_len};
    if (adv_sum > {1'b0, q_high[req_qid]}) begin
      next_head = q_base[req_qid];
    end else begin
      next_head = adv_sum[BD_ADDR_W-1:0];
    end
  end

  always_ff @(posedge user_clk or negedge axi_lite_aresetn) begin
    if (!axi_lite_aresetn) begin
      state <= ST_ARB;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_load = 1'b0;
    handshake  = 1'b0;
    unique case (state)
      ST_ARB: begin
        if (gnt_vld) begin
          grant_load = 1'b1;
          state_nxt  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (req_ready) begin
          handshake = 1'b1;
          state_nxt = ST_ARB;
        end
      end
      default: state_nxt = ST_ARB;
    endcase
  end

  // Request fields are captured at the ARB decision and held until the engine accepts.
  always_ff @(posedge user_clk or negedge axi_lite_aresetn) begin
    if (!axi_lite_aresetn) begin
      req_valid <= 1'b0;
      req_qid   <= '0;
      req_addr  <= '0;
      req_len   <= '0;
      rr_last   <= 2'd3;
    end else if (grant_load) begin
      req_valid <= 1'b1;
      req_qid   <= gnt_id;
      req_addr  <= win_head;
      req_len   <= win_len;
    end else if (handshake) begin
      req_valid <= 1'b0;
      rr_last   <= req_qid;
    end
  end

  // A doorbell landing on the enable edge takes precedence over the rebase of tail.
  always_ff @(posedge user_clk or negedge axi_lite_aresetn) begin
    if (!axi_lite_aresetn) begin
      q_en_d <= '0;
      q_busy <= '0;
      q_halt <= '0;
      for (int i = 0; i < NUM_Q; i++) begin
        head[i] <= '0;
        tail[i] <= '0;
      end
    end else begin
      q_en_d <= q_en;
      for (int i = 0; i < NUM_Q; i++) begin
        if (q_en[i] && !q_en_d[i]) begin
          head[i]   <= q_base[i];
          tail[i]   <= q_base[i];
          q_halt[i] <= 1'b0;
        end else if (handshake && (req_qid == 2'(i))) begin
          head[i] <= next_head;
        end

        if (q_en[i] && tail_wr[i]) begin
          tail[i] <= tail_val;
        end

        if (handshake && (req_qid == 2'(i))) begin
          q_busy[i] <= 1'b1;
        end else if (cpl_valid && (cpl_qid == 2'(i)) && q_busy[i]) begin
          q_busy[i] <= 1'b0;
          if (cpl_err) begin
            q_halt[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bd_fetch_sched.sv
// Scoreboard bench for bd_fetch_sched: a ring-level model predicts the request sequence,
// a monitor/responder process checks each presented request and returns its completion.
module tb_bd_fetch_sched;
  import dma_bd_pkg::*;

  localparam int MAX_BURST = 8;
  localparam int LEN_W     = 7;

  logic                          user_clk = 1'b0;
  logic                          axi_lite_aresetn;
  logic [NUM_Q-1:0][BD_ADDR_W-1:0] q_base;
  logic [NUM_Q-1:0][BD_ADDR_W-1:0] q_high;
  logic [NUM_Q-1:0]              q_en;
  logic [NUM_Q-1:0]              tail_wr;
  logic [BD_ADDR_W-1:0]          tail_val;
  logic                          req_valid;
  logic                          req_ready;
  logic [1:0]                    req_qid;
  logic [BD_ADDR_W-1:0]          req_addr;
  logic [LEN_W-1:0]              req_len;
  logic                          cpl_valid;
  logic [1:0]                    cpl_qid;
  logic                          cpl_err;
  logic [NUM_Q-1:0]              q_busy;
  logic [NUM_Q-1:0]              q_halt;

  always #5 user_clk = ~user_clk;

  bd_fetch_sched #(.MAX_BURST(MAX_BURST), .LEN_W(LEN_W)) dut (
    .user_clk         (user_clk),
    .axi_lite_aresetn (axi_lite_aresetn),
    .q_base           (q_base),
    .q_high           (q_high),
    .q_en             (q_en),
    .tail_wr          (tail_wr),
    .tail_val         (tail_val),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_qid          (req_qid),
    .req_addr         (req_addr),
    .req_len          (req_len),
    .cpl_valid        (cpl_valid),
    .cpl_qid          (cpl_qid),
    .cpl_err          (cpl_err),
    .q_busy           (q_busy),
    .q_halt           (q_halt)
  );

  typedef struct {
    int     qid;
    longint addr;
    int     len;
    bit     err;
  } exp_t;

  exp_t   exp_q[$];
  int     total = 0;
  int     bad   = 0;

  longint m_base [4];
  longint m_high [4];
  longint m_head [4];
  longint m_tail [4];
  bit     m_en   [4];
  bit     m_halt [4];
  int     m_rr;

  longint db_tail [4];
  logic [3:0] db_mask;

  bit     hold_ready = 1'b0;
  int     min_stall  = 0;
  bit     in_req     = 1'b0;
  bit     hs_pend    = 1'b0;

  function automatic void check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [3:0] halt_mask();
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[i] = m_halt[i];
    return m;
  endfunction

  // Ring-level model: keep granting the next non-empty ring in rotation until all are drained.
  function automatic void plan_drain(input int err_ring, input int err_pct);
    bit   err_used;
    int   win;
    int   r;
    longint avail;
    exp_t e;
    err_used = 1'b0;
    forever begin
      win = -1;
      for (int k = 1; k <= 4; k++) begin
        r = (m_rr + k) % 4;
        if (win < 0 && m_en[r] && !m_halt[r] && m_head[r] != m_tail[r]) win = r;
      end
      if (win < 0) break;
      if (m_tail[win] >= m_head[win]) avail = m_tail[win] - m_head[win];
      else                            avail = m_high[win] - m_head[win] + 1;
      e.qid  = win;
      e.addr = m_head[win];
      e.len  = (avail < MAX_BURST) ? int'(avail) : MAX_BURST;
      e.err  = ($urandom_range(0, 99) < err_pct);
      if (win == err_ring && !err_used) begin
        e.err    = 1'b1;
        err_used = 1'b1;
      end
      exp_q.push_back(e);
      m_head[win] = (m_head[win] + e.len > m_high[win]) ? m_base[win] : m_head[win] + e.len;
      m_rr = win;
      if (e.err) m_halt[win] = 1'b1;
    end
  endfunction

  // Monitor and engine responder: pops the expectation when a request first appears.
  initial begin : monitor
    exp_t   cur;
    exp_t   act;
    int     stall_left;
    logic [1:0]           h_qid;
    logic [BD_ADDR_W-1:0] h_addr;
    logic [LEN_W-1:0]     h_len;
    req_ready  = 1'b0;
    cpl_valid  = 1'b0;
    cpl_qid    = '0;
    cpl_err    = 1'b0;
    stall_left = 0;
    h_qid = '0; h_addr = '0; h_len = '0;
    cur.qid = 0; cur.addr = 0; cur.len = 0; cur.err = 1'b0;
    forever begin
      @(negedge user_clk);
      cpl_valid = 1'b0;
      cpl_err   = 1'b0;
      if (!axi_lite_aresetn) begin
        in_req    = 1'b0;
        hs_pend   = 1'b0;
        req_ready = 1'b0;
        continue;
      end
      if (hs_pend) begin
        cpl_valid = 1'b1;
        cpl_qid   = 2'(cur.qid);
        cpl_err   = cur.err;
        hs_pend   = 1'b0;
        in_req    = 1'b0;
      end
      req_ready = 1'b0;
      if (req_valid) begin
        if (!in_req) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_req: got qid=%0d addr=0x%0h len=%0d, expected none",
                     req_qid, req_addr, req_len);
            act.qid = int'(req_qid); act.addr = longint'(req_addr);
            act.len = int'(req_len); act.err = 1'b0;
            cur = act;
          end else begin
            cur = exp_q.pop_front();
            check("req_qid",  longint'(req_qid),  longint'(cur.qid));
            check("req_addr", longint'(req_addr), cur.addr);
            check("req_len",  longint'(req_len),  longint'(cur.len));
          end
          h_qid      = req_qid;
          h_addr     = req_addr;
          h_len      = req_len;
          in_req     = 1'b1;
          stall_left = min_stall + int'($urandom_range(0, 2));
        end else begin
          check("req_stable", longint'({req_qid, req_addr, req_len}),
                longint'({h_qid, h_addr, h_len}));
        end
        if (stall_left > 0) begin
          stall_left--;
        end else if (!hold_ready) begin
          req_ready = 1'b1;
          hs_pend   = 1'b1;
        end
      end
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_req || hs_pend) && n < 4000) begin
      @(negedge user_clk);
      n++;
    end
    check("drain_done", longint'(exp_q.size() == 0 && !in_req && !hs_pend), 1);
    exp_q.delete();
    repeat (4) @(negedge user_clk);
    check("idle_busy", longint'(q_busy), 0);
    check("idle_halt", longint'(q_halt), longint'(halt_mask()));
  endtask

  task automatic enable_ring(input int r, input longint base, input longint high);
    q_base[r] = 27'(base);
    q_high[r] = 27'(high);
    q_en[r]   = 1'b0;
    @(negedge user_clk);
    q_en[r]   = 1'b1;
    @(negedge user_clk);
    @(negedge user_clk);
    m_base[r] = base;
    m_high[r] = high;
    m_head[r] = base;
    m_tail[r] = base;
    m_en[r]   = 1'b1;
    m_halt[r] = 1'b0;
  endtask

  task automatic disable_ring(input int r);
    q_en[r] = 1'b0;
    @(negedge user_clk);
    @(negedge user_clk);
    m_en[r] = 1'b0;
  endtask

  // Doorbells go out in rotation order with the engine stalled, so the first grant
  // cannot overtake a later doorbell.
  task automatic apply_stimulus(input int err_ring, input int err_pct);
    int start_rr;
    int r;
    for (int i = 0; i < 4; i++) begin
      if (db_mask[i] && m_en[i]) m_tail[i] = db_tail[i];
    end
    start_rr = m_rr;
    plan_drain(err_ring, err_pct);
    hold_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      r = (start_rr + k) % 4;
      if (db_mask[r]) begin
        tail_val = 27'(db_tail[r]);
        tail_wr  = 4'(1 << r);
        @(negedge user_clk);
        tail_wr  = '0;
      end
    end
    hold_ready = 1'b0;
    wait_drain();
  endtask

  task automatic check_output_reset();
    check("rst_req_valid", longint'(req_valid), 0);
    check("rst_req_qid",   longint'(req_qid),   0);
    check("rst_req_addr",  longint'(req_addr),  0);
    check("rst_req_len",   longint'(req_len),   0);
    check("rst_q_busy",    longint'(q_busy),    0);
    check("rst_q_halt",    longint'(q_halt),    0);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    longint base;
    longint size;
    int     r;
    int     n;
    axi_lite_aresetn = 1'b0;
    q_base   = '0;
    q_high   = '0;
    q_en     = '0;
    tail_wr  = '0;
    tail_val = '0;
    db_mask  = '0;
    for (int i = 0; i < 4; i++) begin
      m_base[i] = 0; m_high[i] = 0; m_head[i] = 0; m_tail[i] = 0;
      m_en[i] = 1'b0; m_halt[i] = 1'b0; db_tail[i] = 0;
    end
    m_rr = 3;

    repeat (3) @(negedge user_clk);
    check_output_reset();
    axi_lite_aresetn = 1'b1;
    repeat (2) @(negedge user_clk);
    check("post_rst_req_valid", longint'(req_valid), 0);

    $display("[TB] basic request and head advance");
    enable_ring(0, 'h100, 'h10F);
    db_mask = 4'b0001;
    db_tail[0] = 'h103;
    apply_stimulus(-1, 0);
    db_tail[0] = 'h10C;
    apply_stimulus(-1, 0);

    $display("[TB] wrapped ring");
    db_tail[0] = 'h102;
    apply_stimulus(-1, 0);

    $display("[TB] bursts capped at MAX_BURST");
    enable_ring(0, 'h100, 'h1FF);
    db_tail[0] = 'h114;
    apply_stimulus(-1, 0);

    $display("[TB] four rings with held ready");
    enable_ring(1, 'h200, 'h21F);
    enable_ring(2, 'h300, 'h30F);
    enable_ring(3, 'h400, 'h43F);
    db_mask = 4'b1111;
    db_tail[0] = 'h119;
    db_tail[1] = 'h205;
    db_tail[2] = 'h304;
    db_tail[3] = 'h40A;
    min_stall = 5;
    apply_stimulus(-1, 0);
    min_stall = 0;

    $display("[TB] completion error halts ring");
    db_mask = 4'b0100;
    db_tail[2] = 'h30A;
    apply_stimulus(2, 0);
    db_tail[2] = 'h30C;
    apply_stimulus(-1, 0);
    enable_ring(2, 'h300, 'h30F);
    check("halt_clear", longint'(q_halt[2]), 0);
    db_tail[2] = 'h303;
    apply_stimulus(-1, 0);

    $display("[TB] randomized traffic");
    for (int it = 0; it < 30; it++) begin
      r = int'($urandom_range(0, 3));
      n = int'($urandom_range(0, 9));
      if (n < 2) begin
        disable_ring(r);
      end else if (n < 5 || !m_en[r]) begin
        base = longint'($urandom_range(0, 32'h03FF_FFFF));
        size = longint'($urandom_range(3, 40));
        enable_ring(r, base, base + size - 1);
      end
      db_mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        db_tail[i] = m_base[i] + longint'($urandom_range(0, 32'(m_high[i] - m_base[i])));
      end
      min_stall = int'($urandom_range(0, 2));
      apply_stimulus(-1, 10);
    end
    min_stall = 0;

    $display("[TB] reset during an outstanding request");
    enable_ring(1, 'h50, 'h5F);
    db_mask = 4'b0010;
    db_tail[1] = 'h55;
    m_tail[1] = 'h55;
    plan_drain(-1, 0);
    hold_ready = 1'b1;
    tail_val = 27'('h55);
    tail_wr  = 4'b0010;
    @(negedge user_clk);
    tail_wr  = '0;
    n = 0;
    while (!req_valid && n < 20) begin
      @(negedge user_clk);
      n++;
    end
    check("t6_req_seen", longint'(req_valid), 1);
    #2;
    axi_lite_aresetn = 1'b0;
    q_en = '0;
    #1;
    check_output_reset();
    exp_q.delete();
    hold_ready = 1'b0;
    repeat (3) @(negedge user_clk);
    axi_lite_aresetn = 1'b1;
    repeat (3) @(negedge user_clk);
    check("post_rst_idle", longint'(req_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
